// File: rtl/ddr3_axi_lite_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ddr3_axi_lite_arbiter
// Description : Two-master to one-slave AXI4-Lite arbiter, one transaction
//               outstanding, round-robin between masters.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr3_axi_lite_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                        i_controller_clk,
    input  logic                        i_rst_n,
    // Master side, master k packed at slice k
    input  logic [2*ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic [1:0]                  s_axi_awvalid,
    output logic [1:0]                  s_axi_awready,
    input  logic [2*DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [2*DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic [1:0]                  s_axi_wvalid,
    output logic [1:0]                  s_axi_wready,
    output logic [3:0]                  s_axi_bresp,
    output logic [1:0]                  s_axi_bvalid,
    input  logic [1:0]                  s_axi_bready,
    input  logic [2*ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic [1:0]                  s_axi_arvalid,
    output logic [1:0]                  s_axi_arready,
    output logic [2*DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [3:0]                  s_axi_rresp,
    output logic [1:0]                  s_axi_rvalid,
    input  logic [1:0]                  s_axi_rready,
    // Slave side
    output logic [ADDR_WIDTH-1:0]       m_axi_awaddr,
    output logic                        m_axi_awvalid,
    input  logic                        m_axi_awready,
    output logic [DATA_WIDTH-1:0]       m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]     m_axi_wstrb,
    output logic                        m_axi_wvalid,
    input  logic                        m_axi_wready,
    input  logic [1:0]                  m_axi_bresp,
    input  logic                        m_axi_bvalid,
    output logic                        m_axi_bready,
    output logic [ADDR_WIDTH-1:0]       m_axi_araddr,
    output logic                        m_axi_arvalid,
    input  logic                        m_axi_arready,
    input  logic [DATA_WIDTH-1:0]       m_axi_rdata,
    input  logic [1:0]                  m_axi_rresp,
    input  logic                        m_axi_rvalid,
    output logic                        m_axi_rready,
    output logic                        o_grant,
    output logic                        o_busy
);

    localparam int c_STRB_WIDTH = DATA_WIDTH / 8;

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_WR_REQ  = 3'd1;
    localparam logic [2:0] c_WR_RESP = 3'd2;
    localparam logic [2:0] c_RD_REQ  = 3'd3;
    localparam logic [2:0] c_RD_DATA = 3'd4;

    logic [2:0] r_state;
    logic       r_grant;
    logic       r_last_grant;
    logic       r_aw_done;
    logic       r_w_done;

    logic [1:0] w_wreq;
    logic [1:0] w_req;
    logic       w_pick;
    logic [1:0] w_sel;
    logic       w_in_wr_req;
    logic       w_in_wr_resp;
    logic       w_in_rd_req;
    logic       w_in_rd_data;
    logic       w_aw_fin;
    logic       w_w_fin;

    assign w_wreq = s_axi_awvalid & s_axi_wvalid;
    assign w_req  = w_wreq | s_axi_arvalid;
    // Contention goes to whoever was not served last; otherwise the lone requester
    assign w_pick = (&w_req) ? ~r_last_grant : w_req[1];
    assign w_sel  = {r_grant, ~r_grant};

    assign w_in_wr_req  = (r_state == c_WR_REQ);
    assign w_in_wr_resp = (r_state == c_WR_RESP);
    assign w_in_rd_req  = (r_state == c_RD_REQ);
    assign w_in_rd_data = (r_state == c_RD_DATA);

    assign m_axi_awaddr  = r_grant ? s_axi_awaddr[2*ADDR_WIDTH-1:ADDR_WIDTH] : s_axi_awaddr[ADDR_WIDTH-1:0];
    assign m_axi_wdata   = r_grant ? s_axi_wdata[2*DATA_WIDTH-1:DATA_WIDTH]  : s_axi_wdata[DATA_WIDTH-1:0];
    assign m_axi_wstrb   = r_grant ? s_axi_wstrb[2*c_STRB_WIDTH-1:c_STRB_WIDTH] : s_axi_wstrb[c_STRB_WIDTH-1:0];
    assign m_axi_araddr  = r_grant ? s_axi_araddr[2*ADDR_WIDTH-1:ADDR_WIDTH] : s_axi_araddr[ADDR_WIDTH-1:0];

    assign m_axi_awvalid = w_in_wr_req & ~r_aw_done;
    assign m_axi_wvalid  = w_in_wr_req & ~r_w_done;
    assign m_axi_bready  = w_in_wr_resp & s_axi_bready[r_grant];
    assign m_axi_arvalid = w_in_rd_req;
    assign m_axi_rready  = w_in_rd_data & s_axi_rready[r_grant];

    assign w_aw_fin = r_aw_done | (m_axi_awvalid & m_axi_awready);
    assign w_w_fin  = r_w_done  | (m_axi_wvalid  & m_axi_wready);

    generate
        for (genvar k = 0; k < 2; k++) begin : g_master
            assign s_axi_awready[k] = w_sel[k] & m_axi_awvalid & m_axi_awready;
            assign s_axi_wready[k]  = w_sel[k] & m_axi_wvalid & m_axi_wready;
            assign s_axi_bvalid[k]  = w_sel[k] & w_in_wr_resp & m_axi_bvalid;
            assign s_axi_arready[k] = w_sel[k] & w_in_rd_req & m_axi_arready;
            assign s_axi_rvalid[k]  = w_sel[k] & w_in_rd_data & m_axi_rvalid;
            assign s_axi_bresp[2*k +: 2] = w_sel[k] ? m_axi_bresp : 2'b00;
            assign s_axi_rresp[2*k +: 2] = w_sel[k] ? m_axi_rresp : 2'b00;
            assign s_axi_rdata[k*DATA_WIDTH +: DATA_WIDTH] = w_sel[k] ? m_axi_rdata : '0;
        end
    endgenerate

    always_ff @(posedge i_controller_clk) begin
        if (!i_rst_n) begin
            r_state      <= c_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_aw_done    <= 1'b0;
            r_w_done     <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (|w_req) begin
                        r_grant <= w_pick;
                        r_state <= w_wreq[w_pick] ? c_WR_REQ : c_RD_REQ;
                    end
                end
                c_WR_REQ: begin
                    // AW and W may complete in either order or together
                    if (w_aw_fin && w_w_fin) begin
                        r_state   <= c_WR_RESP;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                    end else begin
                        r_aw_done <= w_aw_fin;
                        r_w_done  <= w_w_fin;
                    end
                end
                c_WR_RESP: begin
                    if (m_axi_bvalid && m_axi_bready) begin
                        r_last_grant <= r_grant;
                        r_state      <= c_IDLE;
                    end
                end
                c_RD_REQ: begin
                    if (m_axi_arready) begin
                        r_state <= c_RD_DATA;
                    end
                end
                c_RD_DATA: begin
                    if (m_axi_rvalid && m_axi_rready) begin
                        r_last_grant <= r_grant;
                        r_state      <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign o_grant = r_grant;
    assign o_busy  = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ddr3_axi_lite_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ddr3_axi_lite_arbiter
// Description : Scoreboard bench for ddr3_axi_lite_arbiter with a memory slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr3_axi_lite_arbiter;

    localparam int TMO = 200;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] s_axi_awaddr = '0;
    logic [1:0]  s_axi_awvalid = '0;
    logic [1:0]  s_axi_awready;
    logic [63:0] s_axi_wdata = '0;
    logic [7:0]  s_axi_wstrb = '0;
    logic [1:0]  s_axi_wvalid = '0;
    logic [1:0]  s_axi_wready;
    logic [3:0]  s_axi_bresp;
    logic [1:0]  s_axi_bvalid;
    logic [1:0]  s_axi_bready = 2'b11;
    logic [63:0] s_axi_araddr = '0;
    logic [1:0]  s_axi_arvalid = '0;
    logic [1:0]  s_axi_arready;
    logic [63:0] s_axi_rdata;
    logic [3:0]  s_axi_rresp;
    logic [1:0]  s_axi_rvalid;
    logic [1:0]  s_axi_rready = 2'b11;

    logic [31:0] m_axi_awaddr;
    logic        m_axi_awvalid;
    logic        m_axi_awready = 1'b0;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid;
    logic        m_axi_wready = 1'b0;
    logic [1:0]  m_axi_bresp = 2'b00;
    logic        m_axi_bvalid = 1'b0;
    logic        m_axi_bready;
    logic [31:0] m_axi_araddr;
    logic        m_axi_arvalid;
    logic        m_axi_arready = 1'b0;
    logic [31:0] m_axi_rdata = '0;
    logic [1:0]  m_axi_rresp = 2'b00;
    logic        m_axi_rvalid = 1'b0;
    logic        m_axi_rready;
    logic        o_grant;
    logic        o_busy;

    ddr3_axi_lite_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .i_controller_clk(clk),   .i_rst_n(rst_n),
        .s_axi_awaddr(s_axi_awaddr),   .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata),     .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid),   .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp),     .s_axi_bvalid(s_axi_bvalid),   .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr),   .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata),     .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid),   .s_axi_rready(s_axi_rready),
        .m_axi_awaddr(m_axi_awaddr),   .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata),     .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid),   .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp),     .m_axi_bvalid(m_axi_bvalid),   .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr),   .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata),     .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid),   .m_axi_rready(m_axi_rready),
        .o_grant(o_grant),             .o_busy(o_busy)
    );

    int checks = 0;
    int errors = 0;
    int viol_ungranted = 0;
    int viol_idle = 0;

    logic [14:0] all_hs;
    assign all_hs = {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready,
                     s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        bit          is_rd;
        int          m;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;
    exp_t exp_q[$];

    task automatic push_exp(input bit is_rd, input int m, input logic [31:0] data, input logic [1:0] resp);
        exp_t e;
        e.is_rd = is_rd; e.m = m; e.data = data; e.resp = resp;
        exp_q.push_back(e);
    endtask

    task automatic score(input bit is_rd, input int m, input logic [31:0] data, input logic [1:0] resp);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got rd=%0d m=%0d data=0x%08h resp=%0d, required no response",
                     is_rd, m, data, resp);
        end else begin
            e = exp_q.pop_front();
            if (e.is_rd != is_rd || e.m != m || e.resp !== resp || (is_rd && e.data !== data)) begin
                errors++;
                $display("FAIL sb_resp: got rd=%0d m=%0d data=0x%08h resp=%0d, required rd=%0d m=%0d data=0x%08h resp=%0d",
                         is_rd, m, data, resp, e.is_rd, e.m, e.data, e.resp);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                if (s_axi_bvalid[k] && s_axi_bready[k]) score(1'b0, k, 32'h0, s_axi_bresp[k*2 +: 2]);
                if (s_axi_rvalid[k] && s_axi_rready[k]) score(1'b1, k, s_axi_rdata[k*32 +: 32], s_axi_rresp[k*2 +: 2]);
                if (k != int'(o_grant)) begin
                    if (s_axi_awready[k] || s_axi_wready[k] || s_axi_bvalid[k] || s_axi_arready[k] ||
                        s_axi_rvalid[k] || s_axi_rdata[k*32 +: 32] != 32'h0 || s_axi_bresp[k*2 +: 2] != 2'b00 ||
                        s_axi_rresp[k*2 +: 2] != 2'b00)
                        viol_ungranted++;
                end
            end
            if (!o_busy && all_hs != '0) viol_idle++;
        end
    end

    // ---------------- memory slave ----------------
    int aw_lat = 0, w_lat = 0, aw_wait = 0, w_wait = 0;
    int aw_hs_cnt = 0, w_hs_cnt = 0, awv_cycles = 0, wv_cycles = 0;
    logic sv_aw_hs = 0, sv_w_hs = 0, sv_b_hs = 0, sv_ar_hs = 0, sv_r_hs = 0;
    logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
    logic [3:0]  cap_wstrb = '0;
    bit          aw_have = 0, w_have = 0;
    logic [31:0] sl_awaddr = '0, sl_wdata = '0;
    logic [3:0]  sl_wstrb = '0;
    logic [31:0] mem [0:1023];

    always @(negedge clk) begin
        sv_aw_hs = m_axi_awvalid && m_axi_awready;
        sv_w_hs  = m_axi_wvalid && m_axi_wready;
        sv_b_hs  = m_axi_bvalid && m_axi_bready;
        sv_ar_hs = m_axi_arvalid && m_axi_arready;
        sv_r_hs  = m_axi_rvalid && m_axi_rready;
        cap_awaddr = m_axi_awaddr; cap_wdata = m_axi_wdata;
        cap_wstrb  = m_axi_wstrb;  cap_araddr = m_axi_araddr;
        if (m_axi_awvalid) awv_cycles++;
        if (m_axi_wvalid)  wv_cycles++;
    end

    // Addresses with bit 11 set answer SLVERR so response passthrough is visible
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
            m_axi_arready = 0; m_axi_rvalid = 0;
            aw_have = 0; w_have = 0; aw_wait = 0; w_wait = 0;
        end else begin
            if (sv_aw_hs) begin aw_have = 1; sl_awaddr = cap_awaddr; aw_hs_cnt++; end
            if (sv_w_hs)  begin w_have = 1; sl_wdata = cap_wdata; sl_wstrb = cap_wstrb; w_hs_cnt++; end
            if (sv_b_hs)  m_axi_bvalid = 0;
            if (aw_have && w_have && !m_axi_bvalid) begin
                for (int b = 0; b < 4; b++)
                    if (sl_wstrb[b]) mem[sl_awaddr[11:2]][b*8 +: 8] = sl_wdata[b*8 +: 8];
                m_axi_bvalid = 1;
                m_axi_bresp  = sl_awaddr[11] ? 2'b10 : 2'b00;
                aw_have = 0; w_have = 0;
            end
            if (m_axi_awvalid && !aw_have) begin
                if (aw_wait >= aw_lat) m_axi_awready = 1;
                else begin m_axi_awready = 0; aw_wait++; end
            end else begin
                m_axi_awready = 0; aw_wait = 0;
            end
            if (m_axi_wvalid && !w_have) begin
                if (w_wait >= w_lat) m_axi_wready = 1;
                else begin m_axi_wready = 0; w_wait++; end
            end else begin
                m_axi_wready = 0; w_wait = 0;
            end
            if (sv_r_hs) m_axi_rvalid = 0;
            if (sv_ar_hs) begin
                m_axi_rvalid = 1;
                m_axi_rdata  = mem[cap_araddr[11:2]];
                m_axi_rresp  = cap_araddr[11] ? 2'b10 : 2'b00;
            end
            m_axi_arready = m_axi_arvalid;
        end
    end

    // ---------------- master drivers ----------------
    task automatic wait_resp(input int m, input bit is_rd);
        int n = 0;
        bit got = 0;
        while (!got && n < TMO) begin
            @(negedge clk);
            if (is_rd) got = s_axi_rvalid[m] && s_axi_rready[m];
            else       got = s_axi_bvalid[m] && s_axi_bready[m];
            n++;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL resp_timeout: master %0d rd=%0d got no response, required one within %0d cycles", m, is_rd, TMO);
        end
    endtask

    task automatic mwrite(input int m, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input bit wait_b);
        bit aw_ok = 0, w_ok = 0;
        int n = 0;
        @(posedge clk); #1;
        s_axi_awaddr[m*32 +: 32] = addr;
        s_axi_wdata[m*32 +: 32]  = data;
        s_axi_wstrb[m*4 +: 4]    = strb;
        s_axi_awvalid[m] = 1'b1;
        s_axi_wvalid[m]  = 1'b1;
        while (!(aw_ok && w_ok) && n < TMO) begin
            @(negedge clk);
            if (s_axi_awvalid[m] && s_axi_awready[m]) aw_ok = 1;
            if (s_axi_wvalid[m] && s_axi_wready[m])   w_ok = 1;
            @(posedge clk); #1;
            if (aw_ok) s_axi_awvalid[m] = 1'b0;
            if (w_ok)  s_axi_wvalid[m]  = 1'b0;
            n++;
        end
        s_axi_awvalid[m] = 1'b0;
        s_axi_wvalid[m]  = 1'b0;
        if (!(aw_ok && w_ok)) begin
            checks++; errors++;
            $display("FAIL wr_req_timeout: master %0d aw=%0d w=%0d, required both accepted", m, aw_ok, w_ok);
        end else if (wait_b) begin
            wait_resp(m, 1'b0);
        end
    endtask

    task automatic mread(input int m, input logic [31:0] addr);
        bit ar_ok = 0;
        int n = 0;
        @(posedge clk); #1;
        s_axi_araddr[m*32 +: 32] = addr;
        s_axi_arvalid[m] = 1'b1;
        while (!ar_ok && n < TMO) begin
            @(negedge clk);
            if (s_axi_arvalid[m] && s_axi_arready[m]) ar_ok = 1;
            @(posedge clk); #1;
            n++;
        end
        s_axi_arvalid[m] = 1'b0;
        if (!ar_ok) begin
            checks++; errors++;
            $display("FAIL rd_req_timeout: master %0d arready never seen, required within %0d cycles", m, TMO);
        end else begin
            wait_resp(m, 1'b1);
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1; rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_handshakes", {17'h0, all_hs}, 32'h0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_grant", o_grant, 1'b0);
        @(posedge clk); #1; rst_n = 1'b1;

        // Single write, one-cycle arbitration latency
        push_exp(0, 0, 32'h0, 2'b00);
        @(negedge clk);
        fork
            mwrite(0, 32'h10, 32'hDEADBEEF, 4'hF, 1);
            begin
                @(negedge clk);
                check("t1_arb_cycle_awvalid", m_axi_awvalid, 1'b0);
                @(negedge clk);
                check("t1_awvalid", m_axi_awvalid, 1'b1);
                check("t1_wvalid", m_axi_wvalid, 1'b1);
                check("t1_awaddr", m_axi_awaddr, 32'h10);
                check("t1_wdata", m_axi_wdata, 32'hDEADBEEF);
                check("t1_wstrb", m_axi_wstrb, 4'hF);
                check("t1_grant", o_grant, 1'b0);
            end
        join
        @(negedge clk);
        check("t1_busy_after", o_busy, 1'b0);

        // Split AW/W: W accepted 3 cycles after AW
        @(posedge clk); #1;
        w_lat = 3; aw_hs_cnt = 0; w_hs_cnt = 0; awv_cycles = 0; wv_cycles = 0;
        push_exp(0, 0, 32'h0, 2'b00);
        mwrite(0, 32'h14, 32'h0000BEEF, 4'hF, 1);
        check("split_aw_count", aw_hs_cnt, 1);
        check("split_w_count", w_hs_cnt, 1);
        check("split_awvalid_cycles", awv_cycles, 1);
        check("split_wvalid_cycles", wv_cycles, 4);
        w_lat = 0;

        // Write via master 1, read back via master 0, then byte-lane merge
        push_exp(0, 1, 32'h0, 2'b00);
        push_exp(1, 0, 32'h12345678, 2'b00);
        push_exp(0, 0, 32'h0, 2'b00);
        push_exp(1, 0, 32'h1234CCDD, 2'b00);
        mwrite(1, 32'h100, 32'h12345678, 4'hF, 1);
        mread(0, 32'h100);
        mwrite(0, 32'h100, 32'hAABBCCDD, 4'h3, 1);
        mread(0, 32'h100);

        // Simultaneous reads straight after reset: master 0 first
        push_exp(0, 0, 32'h0, 2'b00);
        push_exp(0, 1, 32'h0, 2'b00);
        mwrite(0, 32'h20, 32'hA5A50020, 4'hF, 1);
        mwrite(1, 32'h40, 32'h5A5A0040, 4'hF, 1);
        pulse_reset();
        push_exp(1, 0, 32'hA5A50020, 2'b00);
        push_exp(1, 1, 32'h5A5A0040, 2'b00);
        fork
            mread(0, 32'h20);
            mread(1, 32'h40);
        join

        // Both masters streaming writes: strict alternation 0,1,0,1,...
        for (int i = 0; i < 4; i++) begin
            push_exp(0, 0, 32'h0, 2'b00);
            push_exp(0, 1, 32'h0, 2'b00);
        end
        fork
            for (int i = 0; i < 4; i++) mwrite(0, 32'h300 + 32'(i*4), 32'h10000000 + 32'(i), 4'hF, 1);
            for (int j = 0; j < 4; j++) mwrite(1, 32'h380 + 32'(j*4), 32'h20000000 + 32'(j), 4'hF, 1);
        join
        push_exp(1, 0, 32'h20000003, 2'b00);
        push_exp(1, 1, 32'h10000001, 2'b00);
        mread(0, 32'h38C);
        mread(1, 32'h304);

        // Same master requesting write and read together: write goes first
        push_exp(0, 0, 32'h0, 2'b00);
        push_exp(1, 0, 32'hCAFEF00D, 2'b00);
        fork
            mwrite(0, 32'h200, 32'hCAFEF00D, 4'hF, 1);
            mread(0, 32'h200);
        join

        // Error response passthrough
        push_exp(0, 1, 32'h0, 2'b10);
        push_exp(1, 0, 32'h55AA55AA, 2'b10);
        mwrite(1, 32'h800, 32'h55AA55AA, 4'hF, 1);
        mread(0, 32'h800);

        // Reset while parked in WR_RESP with bready low
        s_axi_bready[0] = 1'b0;
        mwrite(0, 32'h10, 32'h0BADF00D, 4'hF, 0);
        repeat (2) @(negedge clk);
        check("wrresp_busy", o_busy, 1'b1);
        check("wrresp_bvalid_held", s_axi_bvalid[0], 1'b1);
        @(posedge clk); #1; rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_handshakes", {17'h0, all_hs}, 32'h0);
        check("midrst_busy", o_busy, 1'b0);
        check("midrst_grant", o_grant, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        s_axi_bready[0] = 1'b1;
        repeat (3) @(negedge clk);

        check("sb_queue_empty", exp_q.size(), 0);
        check("ungranted_quiet", viol_ungranted, 0);
        check("idle_quiet", viol_idle, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
